// File: rtl/stream_resize_filter.sv
// Streaming integer-factor resizer: box-average downscale or nearest-neighbour
// upscale by S in 1..MAX_SCALE, using a single line buffer / accumulator row.
module stream_resize_filter #(
  parameter int PIX_W     = 8,
  parameter int CH        = 1,
  parameter int MAX_W     = 512,
  parameter int MAX_SCALE = 10,
  parameter int DIM_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [7:0]          scale,
  input  logic                enlarge,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_W*CH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PIX_W*CH-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);
  localparam int ACC_W = PIX_W + 2 * $clog2(MAX_SCALE) + 1;
  localparam int AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [7:0]       MAX_S  = 8'(MAX_SCALE);
  localparam logic [DIM_W-1:0] MAX_WD = DIM_W'(MAX_W);
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, REPLAY, FLUSH, DONE} state_t;
  state_t state, state_n;

  logic [DIM_W-1:0] width_q, height_q, out_w_q, used_w_q, used_h_q;
  logic [7:0]       scale_q;
  logic [15:0]      sq_q;
  logic             enlarge_q;

  // In upscale, col / col_in_blk / row_in_blk double as replay column,
  // horizontal repeat and vertical repeat counters.
  logic [DIM_W-1:0] col, row, out_col;
  logic [7:0]       col_in_blk, row_in_blk;

  logic [CH*ACC_W-1:0] line_mem [MAX_W];
  logic [CH*ACC_W-1:0] acc_rd, acc_wr;
  logic [AW-1:0]       mem_addr;
  logic                mem_we;

  logic [PIX_W*CH-1:0] out_reg, avg, line_pix;
  logic                out_reg_valid, out_reg_last;

  logic [7:0]       div_s;
  logic [DIM_W-1:0] cfg_out_w, cfg_out_h;
  logic             cfg_bad;
  logic             in_fire, out_fire;
  logic             row_end, frame_end, in_region, first_in_blk, blk_done;
  logic             rep_last, rep_end;

  assign div_s     = (scale == 8'd0) ? 8'd1 : scale;
  assign cfg_out_w = width / DIM_W'(div_s);
  assign cfg_out_h = height / DIM_W'(div_s);
  assign cfg_bad   = (scale == 8'd0) || (scale > MAX_S) ||
                     (width == '0) || (width > MAX_WD) || (height == '0) ||
                     (!enlarge && ((width < DIM_W'(scale)) || (height < DIM_W'(scale))));

  assign in_ready  = (state == LOAD) && (enlarge_q || !out_reg_valid || out_ready);
  assign out_valid = (state == REPLAY) || out_reg_valid;
  assign out_data  = (state == REPLAY) ? line_pix : out_reg;
  assign out_last  = (state == REPLAY) ? rep_last : out_reg_last;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign row_end      = (col == width_q - ONE);
  assign frame_end    = row_end && (row == height_q - ONE);
  assign in_region    = (col < used_w_q) && (row < used_h_q);
  assign first_in_blk = (col_in_blk == 8'd0) && (row_in_blk == 8'd0);
  assign blk_done     = in_region && (col_in_blk == scale_q - 8'd1) &&
                        (row_in_blk == scale_q - 8'd1);
  assign rep_last     = row_end && (col_in_blk == scale_q - 8'd1);
  assign rep_end      = rep_last && (row_in_blk == scale_q - 8'd1);

  assign mem_addr = enlarge_q ? col[AW-1:0] : out_col[AW-1:0];
  assign mem_we   = in_fire && (enlarge_q || in_region);
  assign acc_rd   = line_mem[mem_addr];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [ACC_W-1:0] pix_ext, base, sum;
    assign pix_ext = ACC_W'(in_data[c*PIX_W +: PIX_W]);
    // The first pixel of a block overwrites, which is what clears the entry.
    assign base    = first_in_blk ? '0 : acc_rd[c*ACC_W +: ACC_W];
    assign sum     = base + pix_ext;
    assign acc_wr[c*ACC_W +: ACC_W]  = enlarge_q ? pix_ext : sum;
    assign avg[c*PIX_W +: PIX_W]     = PIX_W'(sum / ACC_W'(sq_q));
    assign line_pix[c*PIX_W +: PIX_W] = acc_rd[c*ACC_W +: PIX_W];
  end

  // NOTE: the line buffer has no reset; stale entries are never read because
  // every block starts by overwriting, and upscale rows are written before replay.
  always_ff @(posedge clk) begin
    if (mem_we) line_mem[mem_addr] <= acc_wr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:   if (start) state_n = cfg_bad ? DONE : LOAD;
      LOAD: begin
        busy = 1'b1;
        if (in_fire && enlarge_q && row_end)        state_n = REPLAY;
        else if (in_fire && !enlarge_q && frame_end) state_n = FLUSH;
      end
      REPLAY: begin
        busy = 1'b1;
        if (out_fire && rep_end) state_n = (row == height_q - ONE) ? DONE : LOAD;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!out_reg_valid || out_ready) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q       <= '0;
      height_q      <= '0;
      out_w_q       <= '0;
      used_w_q      <= '0;
      used_h_q      <= '0;
      scale_q       <= '0;
      sq_q          <= '0;
      enlarge_q     <= 1'b0;
      col           <= '0;
      row           <= '0;
      out_col       <= '0;
      col_in_blk    <= '0;
      row_in_blk    <= '0;
      out_reg       <= '0;
      out_reg_valid <= 1'b0;
      out_reg_last  <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cfg_err    <= cfg_bad;
          col        <= '0;
          row        <= '0;
          out_col    <= '0;
          col_in_blk <= '0;
          row_in_blk <= '0;
          if (!cfg_bad) begin
            width_q   <= width;
            height_q  <= height;
            scale_q   <= scale;
            enlarge_q <= enlarge;
            sq_q      <= 16'(scale) * 16'(scale);
            out_w_q   <= cfg_out_w;
            used_w_q  <= cfg_out_w * DIM_W'(scale);
            used_h_q  <= cfg_out_h * DIM_W'(scale);
          end
        end
        LOAD: if (in_fire) begin
          if (enlarge_q) begin
            col <= row_end ? '0 : col + ONE;
          end else if (row_end) begin
            col        <= '0;
            col_in_blk <= '0;
            out_col    <= '0;
            row        <= row + ONE;
            row_in_blk <= (row_in_blk == scale_q - 8'd1) ? 8'd0 : row_in_blk + 8'd1;
          end else begin
            col <= col + ONE;
            if (col_in_blk == scale_q - 8'd1) begin
              col_in_blk <= '0;
              out_col    <= out_col + ONE;
            end else begin
              col_in_blk <= col_in_blk + 8'd1;
            end
          end
        end
        REPLAY: if (out_fire) begin
          if (col_in_blk == scale_q - 8'd1) begin
            col_in_blk <= '0;
            if (row_end) begin
              col <= '0;
              if (row_in_blk == scale_q - 8'd1) begin
                row_in_blk <= '0;
                row        <= row + ONE;
              end else begin
                row_in_blk <= row_in_blk + 8'd1;
              end
            end else begin
              col <= col + ONE;
            end
          end else begin
            col_in_blk <= col_in_blk + 8'd1;
          end
        end
        default: ;
      endcase

      // Single downscale output slot; in_ready guarantees it is free when loaded.
      if (in_fire && !enlarge_q && blk_done) begin
        out_reg_valid <= 1'b1;
        out_reg       <= avg;
        out_reg_last  <= (out_col == out_w_q - ONE);
      end else if (out_ready) begin
        out_reg_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_resize_filter.sv
// Randomised bench for stream_resize_filter: reference model builds the expected
// output stream from whole frames; handshake rules are checked every cycle.
module tb_stream_resize_filter;
  localparam int PIX_W = 8;
  localparam int CH    = 3;
  localparam int MAX_W = 512;
  localparam int MAX_S = 10;
  localparam int DIM_W = 16;
  localparam int PW    = PIX_W * CH;
  localparam int LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst, start, enlarge, in_valid, out_ready;
  logic [DIM_W-1:0] width, height;
  logic [7:0]    scale;
  logic          in_ready, out_valid, out_last, busy, done, cfg_err;
  logic [PW-1:0] in_data, out_data;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] pix_q[$];
  logic [PW:0]   exp_q[$];
  logic [PW:0]   got_q[$];

  stream_resize_filter #(
    .PIX_W(PIX_W), .CH(CH), .MAX_W(MAX_W), .MAX_SCALE(MAX_S), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .scale(scale), .enlarge(enlarge), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: channel 0 = base + k*step; mode 1: random; mode 2: all ones
  task automatic fill(input int n, input int mode, input int base, input int step);
    pix_q.delete();
    for (int k = 0; k < n; k++) begin
      logic [PW-1:0] p;
      p = PW'($urandom);
      if (mode == 0) p[PIX_W-1:0] = PIX_W'(base + k * step);
      if (mode == 2) p = '1;
      pix_q.push_back(p);
    end
  endtask

  task automatic build_expected(input int w, input int h, input int s, input bit enl);
    exp_q.delete();
    if (enl) begin
      for (int y = 0; y < h; y++)
        for (int r = 0; r < s; r++)
          for (int x = 0; x < w; x++)
            for (int d = 0; d < s; d++)
              exp_q.push_back({(x == w - 1) && (d == s - 1), pix_q[y * w + x]});
    end else begin
      for (int oy = 0; oy < h / s; oy++)
        for (int ox = 0; ox < w / s; ox++) begin
          logic [PW-1:0] v;
          v = '0;
          for (int c = 0; c < CH; c++) begin
            int sum;
            logic [PW-1:0] p;
            sum = 0;
            for (int dy = 0; dy < s; dy++)
              for (int dx = 0; dx < s; dx++) begin
                p = pix_q[(oy * s + dy) * w + ox * s + dx];
                sum += int'(p[c*PIX_W +: PIX_W]);
              end
            v[c*PIX_W +: PIX_W] = PIX_W'(sum / (s * s));
          end
          exp_q.push_back({ox == w / s - 1, v});
        end
    end
  endtask

  function automatic bit completes(input int k, input int w, input int h, input int s, input bit enl);
    int x, y;
    x = k % w;
    y = k / w;
    if (enl) return x == w - 1;
    return (x < (w / s) * s) && (y < (h / s) * s) && (x % s == s - 1) && (y % s == s - 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // vmode 0: in_valid steady, 1: random. rmode 0: ready, 1: random, 2: 1,0,0,1 pattern.
  task automatic run_frame(input string name, input int w, input int h, input int s,
                           input bit enl, input bit exp_err, input int vmode, input int rmode);
    int idx, cyc, done_cnt, rdy_seen, extra, done_cyc, last_out_cyc, n_in;
    bit prev_stall, expect_ov;
    logic [PW:0] prev_out;
    n_in = exp_err ? 0 : w * h;
    if (exp_err) exp_q.delete();
    else build_expected(w, h, s, enl);
    got_q.delete();
    idx = 0; cyc = 0; done_cnt = 0; rdy_seen = 0; extra = 0;
    done_cyc = -1; last_out_cyc = -1; prev_stall = 0; expect_ov = 0; prev_out = '0;

    @(negedge clk);
    width = DIM_W'(w); height = DIM_W'(h); scale = 8'(s); enlarge = enl; start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    while (cyc < LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = exp_err || ((idx < n_in) && (vmode == 0 || $urandom_range(0, 2) != 0));
      in_data  = (idx < n_in) ? pix_q[idx] : PW'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      #1;
      if (cyc == 0) check({name, " busy_start"}, busy, !exp_err);
      if (prev_stall) begin
        check({name, " hold_valid"}, out_valid, 1'b1);
        check({name, " hold_data"}, {out_last, out_data}, prev_out);
      end
      if (expect_ov) check({name, " out_latency"}, out_valid, 1'b1);
      if (out_valid && !out_ready) check({name, " stall_in_ready"}, in_ready, 1'b0);
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
      expect_ov  = 0;
      if (in_ready) rdy_seen++;
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        last_out_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (!exp_err) expect_ov = completes(idx, w, h, s, enl);
        idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cyc++;
      if (done) break;
    end
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (done) done_cnt++;
      if (out_valid) extra++;
    end

    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " cfg_err"}, cfg_err, exp_err);
    check({name, " busy_end"}, busy, 1'b0);
    check({name, " accepted"}, idx, n_in);
    check({name, " extra_out"}, extra, 0);
    check({name, " out_count"}, got_q.size(), exp_q.size());
    if (exp_err) begin
      check({name, " in_ready_seen"}, rdy_seen, 0);
      check({name, " err_done_lat"}, done_cyc, 0);
    end else if (enl || (w % s == 0 && h % s == 0)) begin
      check({name, " done_lat"}, done_cyc, last_out_cyc + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s px%0d", name, i), got_q[i], exp_q[i]);
    if (done_cnt == 0) do_reset();
  endtask

  task automatic reset_mid_frame();
    int k, cyc;
    fill(16, 0, 0, 1);
    @(negedge clk);
    width = 16'd4; height = 16'd4; scale = 8'd2; enlarge = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 50) begin
      in_data = pix_q[k];
      #1;
      if (in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("rst_mid pixels_fed", k, 5);
    check("rst_mid busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid in_ready", in_ready, 1'b0);
    check("rst_mid out_valid", out_valid, 1'b0);
    check("rst_mid out_data", out_data, '0);
    check("rst_mid out_last", out_last, 1'b0);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid done", done, 1'b0);
    check("rst_mid cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done) k++;
    end
    check("rst_mid no_done", k, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; enlarge = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    width = '0; height = '0; scale = '0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, '0);
    check("reset out_last", out_last, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    fill(16, 0, 0, 1);   run_frame("ds4x4",   4, 4, 2, 1'b0, 1'b0, 0, 0);
    fill(2, 0, 10, 10);  run_frame("us2x1",   2, 1, 3, 1'b1, 1'b0, 0, 0);
    fill(15, 0, 0, 1);   run_frame("ds5x3",   5, 3, 2, 1'b0, 1'b0, 0, 0);
    fill(48, 1, 0, 0);   run_frame("ds_stall", 8, 6, 2, 1'b0, 1'b0, 0, 2);
    fill(63, 1, 0, 0);   run_frame("ds_stall3", 9, 7, 3, 1'b0, 1'b0, 1, 2);
    fill(12, 1, 0, 0);   run_frame("us_stall", 4, 3, 2, 1'b1, 1'b0, 1, 2);

    run_frame("err_s0",   4, 4, 0,         1'b0, 1'b1, 0, 0);
    run_frame("err_smax", 4, 4, MAX_S + 1, 1'b1, 1'b1, 0, 0);
    run_frame("err_w_lt_s", 3, 8, 4,       1'b0, 1'b1, 0, 0);
    run_frame("err_wide", MAX_W + 1, 2, 1, 1'b1, 1'b1, 0, 0);
    fill(16, 0, 0, 1);   run_frame("after_err", 4, 4, 2, 1'b0, 1'b0, 0, 0);

    fill(200, 2, 0, 0);  run_frame("ds_max_sum", 20, 10, MAX_S, 1'b0, 1'b0, 0, 0);
    fill(MAX_W * 10, 1, 0, 0); run_frame("ds_full_w", MAX_W, 10, MAX_S, 1'b0, 1'b0, 0, 1);
    fill(MAX_W * 2, 1, 0, 0);  run_frame("us_full_w", MAX_W, 2, 1, 1'b1, 1'b0, 1, 1);
    fill(20, 1, 0, 0);   run_frame("ds_s1", 5, 4, 1, 1'b0, 1'b0, 1, 1);

    reset_mid_frame();
    fill(16, 0, 0, 1);   run_frame("after_rst", 4, 4, 2, 1'b0, 1'b0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      int s, w, h;
      bit enl;
      enl = 1'($urandom_range(0, 1));
      s = $urandom_range(1, enl ? 4 : MAX_S);
      w = enl ? $urandom_range(1, 12) : $urandom_range(s, 24);
      h = enl ? $urandom_range(1, 5)  : $urandom_range(s, 2 * s + 3);
      fill(w * h, 1, 0, 0);
      run_frame($sformatf("rnd%0d", t), w, h, s, enl, 1'b0, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_resize_filter.md
Name: stream_resize_filter

Overview:
- Streaming integer-factor image resizer: box-average downscale or nearest-neighbour upscale, 1..MAX_SCALE.
- Successor to the frame-buffered resizer. Uses one line buffer/accumulator row instead of a full frame.
- Adds multi-channel pixels, valid/ready handshakes on both sides, and runtime frame size.
- Sits between the pixel source and downstream filters in the image pipeline.

Parameters:
PIX_W, 8, bits per channel
CH, 1, channels per pixel, packed with channel 0 in the LSBs
MAX_W, 512, maximum input width (line buffer depth)
MAX_SCALE, 10, maximum scale factor
DIM_W, 16, width of the dimension inputs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches config, begins a frame
width  in  DIM_W  input width in pixels
height  in  DIM_W  input height in pixels
scale  in  8  scale factor S
enlarge  in  1  1 = upscale, 0 = downscale
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts input pixel
in_data  in  PIX_W*CH  input pixel, raster order
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_data  out  PIX_W*CH  output pixel
out_last  out  1  marks the last pixel of each output row
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final output pixel transfers
cfg_err  out  1  sticky; cleared by the next start or by rst

Behaviour:
- One clock, clk; synchronous active-high reset, rst.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, cfg_err=0. Accumulators cleared, FSM=IDLE.
- rst mid-frame aborts immediately: partial output is discarded and no done pulse is issued.
- A transfer occurs on valid&&ready. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- States: IDLE, LOAD, REPLAY, FLUSH, DONE.
- IDLE, on start:
  - Invalid config if S==0, S>MAX_SCALE, width==0, width>MAX_W, or height==0.
  - Downscale only: also invalid if width<S or height<S.
  - Invalid config sets cfg_err=1, pulses done the next cycle, returns to IDLE, and accepts no pixels.
  - Valid config latches width/height/S/mode, sets busy=1, goes to LOAD.
  - start while busy is ignored.
- Downscale (enlarge=0), in LOAD:
  - Counters: col, row, col_in_blk, row_in_blk, out_col.
  - Each accepted pixel adds per channel into acc[out_col]. Accumulator width is PIX_W+2*ceil(log2(MAX_SCALE))+1.
  - Columns >= (width/S)*S and rows >= (height/S)*S are accepted and discarded. Truncating division throughout.
  - When row_in_blk==S-1 and col_in_blk==S-1, the output is acc/(S*S) per channel, truncated.
  - That output is loaded into the single output register. Then acc[out_col] is cleared.
  - in_ready = !out_valid || out_ready, so at most one output is in flight and backpressure stalls the input.
  - Latency: the output is valid the cycle after the completing input transfer.
  - out_last=1 for the output with out_col == width/S-1.
  - After the last input pixel (row==height-1, col==width-1) go to FLUSH. FLUSH waits for the output to drain, then DONE.
- Upscale (enlarge=1):
  - LOAD: accept exactly width pixels into the line buffer; in_ready=1, out_valid=0.
  - Then REPLAY: emit the row S times. Each pixel is repeated S times horizontally, giving width*S pixels per output row; in_ready=0.
  - out_last=1 on the final pixel of each output row.
  - After S output rows: if rows remain, go to LOAD; else DONE.
  - First output pixel is valid the cycle after the last row pixel is accepted.
  - Output size is (width*S) x (height*S).
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- S==1 passes pixels through in both modes.
- Accumulator sums never overflow at the max config.

Test Plan:
- Downscale 4x4, S=2, pixels 0..15 raster, out_ready=1 -> outputs 2,4,10,12; out_last on the 2nd and 4th; one done pulse.
- Upscale 2x1, S=3, pixels [10,20] -> 3 rows of 10,10,10,20,20,20. out_last on output pixels 6, 12, 18; 18 outputs total.
- Downscale 5x3, S=2, pixels 0..14 -> outputs floor((0+1+5+6)/4)=3 and floor((2+3+7+8)/4)=5. Column 4 and row 2 are consumed and dropped; all 15 inputs accepted.
- CH=3 downscale with out_ready toggling 1,0,0,1 -> out_data stable while stalled, in_ready low while stalled, per-channel averages correct, no lost or duplicated pixels.
- Invalid configs:
  - start with scale=0 -> cfg_err=1, done pulse, in_ready never asserted.
  - scale=MAX_SCALE+1 -> same response.
  - downscale with width<S -> same response.
- rst asserted after 5 input pixels of a frame -> next cycle all outputs at reset values. A fresh start then produces a correct complete frame.
